// File: rtl/key_pkg.sv
// key_pkg: shared FSM state encoding and ms-to-cycle conversion for the key conditioner.
package key_pkg;
    typedef enum logic [2:0] {IDLE, DB_DN, HELD, REPEAT, DB_UP} key_state_t;

    function automatic int ms_to_cycles(input int ms, input int clk_hz);
        return ms * (clk_hz / 1000);
    endfunction
endpackage

// File: rtl/key_channel.sv
// key_channel: synchronizes one raw active-low key and turns it into a debounced
// level plus click/long/step/release pulses, all registered.
module key_channel
    import key_pkg::*;
#(
    parameter int D = 10,
    parameter int H = 1000,
    parameter int R = 200
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_key_n,
    output logic o_pressed,
    output logic o_click,
    output logic o_long,
    output logic o_step,
    output logic o_release
);
    localparam int M = (D > H) ? ((D > R) ? D : R) : ((H > R) ? H : R);
    localparam int CW = (M < 2) ? 1 : $clog2(M);

    logic [1:0] r_sync;
    key_state_t r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic w_up, w_click, w_long, w_step, w_release;

    // w_up = 1 means the synchronized key reads released
    assign w_up = r_sync[1];

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt + 1'b1;
        w_click   = 1'b0;
        w_long    = 1'b0;
        w_step    = 1'b0;
        w_release = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt = '0;
                if (!w_up) w_state = DB_DN;
            end
            DB_DN: begin
                if (w_up) w_state = IDLE;
                else if (r_cnt == CW'(D - 1)) begin
                    w_state = HELD;
                    w_cnt   = '0;
                    w_click = 1'b1;
                    w_step  = 1'b1;
                end
            end
            HELD: begin
                if (w_up) begin
                    w_state = DB_UP;
                    w_cnt   = '0;
                end else if (r_cnt == CW'(H - 1)) begin
                    w_state = REPEAT;
                    w_cnt   = '0;
                    w_long  = 1'b1;
                    w_step  = 1'b1;
                end
            end
            REPEAT: begin
                if (w_up) begin
                    w_state = DB_UP;
                    w_cnt   = '0;
                end else if (r_cnt == CW'(R - 1)) begin
                    w_cnt  = '0;
                    w_step = 1'b1;
                end
            end
            DB_UP: begin
                if (!w_up) begin
                    w_state = HELD;
                    w_cnt   = '0;
                end else if (r_cnt == CW'(D - 1)) begin
                    w_state   = IDLE;
                    w_release = 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync    <= 2'b11;
            r_state   <= IDLE;
            r_cnt     <= '0;
            o_pressed <= 1'b0;
            o_click   <= 1'b0;
            o_long    <= 1'b0;
            o_step    <= 1'b0;
            o_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_key_n};
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            o_pressed <= w_state inside {HELD, REPEAT, DB_UP};
            o_click   <= w_click;
            o_long    <= w_long;
            o_step    <= w_step;
            o_release <= w_release;
        end
    end
endmodule

// File: rtl/key_events.sv
// key_events: N independent key channels; a key's step is suppressed while any
// other key is held so plus/minus never fire together.
module key_events
    import key_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int N_KEYS      = 3,
    parameter int DEBOUNCE_MS = 10,
    parameter int HOLD_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] click,
    output logic [N_KEYS-1:0] long,
    output logic [N_KEYS-1:0] step,
    output logic [N_KEYS-1:0] release_evt
);
    localparam int D = ms_to_cycles(DEBOUNCE_MS, CLK_HZ);
    localparam int H = ms_to_cycles(HOLD_MS, CLK_HZ);
    localparam int R = ms_to_cycles(REPEAT_MS, CLK_HZ);

    logic [N_KEYS-1:0] w_step;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
        key_channel #(.D(D), .H(H), .R(R)) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_key_n  (key_n[k]),
            .o_pressed(pressed[k]),
            .o_click  (click[k]),
            .o_long   (long[k]),
            .o_step   (w_step[k]),
            .o_release(release_evt[k])
        );
        assign step[k] = w_step[k] & ~|(pressed & ~(N_KEYS'(1) << k));
    end
endmodule

// File: tb/tb_key_events.sv
// tb_key_events: directed plus random key stimulus checked against a timer-based
// reference model through an event scoreboard.
module tb_key_events;
    localparam int N = 3, D = 4, H = 20, R = 5;

    logic clk = 1'b0, reset_n = 1'b1;
    logic [N-1:0] key_n = '1;
    logic [N-1:0] pressed, click, long, step, release_evt;

    key_events #(.CLK_HZ(1000), .N_KEYS(N), .DEBOUNCE_MS(4), .HOLD_MS(20), .REPEAT_MS(5)) dut (
        .clk(clk), .reset_n(reset_n), .key_n(key_n), .pressed(pressed),
        .click(click), .long(long), .step(step), .release_evt(release_evt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int           cyc;
        logic [4*N-1:0] ev;
    } rec_t;

    rec_t q[$];
    int cyc = 0, ntests = 0, nfail = 0;

    // model: key level delayed two edges, run length of that level, and a hold
    // timer counting edges since the press (or since returning from a glitch)
    logic [N-1:0] m_s1 = '1, m_s2 = '1, m_last = '1, m_p = '0;
    int m_run [N];
    int m_t [N];

    always @(posedge clk or negedge reset_n) begin
        logic [N-1:0] c, l, s, r;
        logic v;
        rec_t e;
        if (!reset_n) begin
            m_s1 = '1; m_s2 = '1; m_last = '1; m_p = '0;
            for (int i = 0; i < N; i++) begin m_run[i] = 0; m_t[i] = -1; end
            q.delete();
        end else begin
            cyc++;
            c = '0; l = '0; s = '0; r = '0;
            for (int i = 0; i < N; i++) begin
                v = m_s2[i];
                m_run[i] = (v == m_last[i]) ? m_run[i] + 1 : 1;
                m_last[i] = v;
                if (!m_p[i]) begin
                    if (!v && m_run[i] == D + 1) begin
                        m_p[i] = 1'b1; c[i] = 1'b1; s[i] = 1'b1; m_t[i] = 0;
                    end
                end else if (v) begin
                    m_t[i] = -1;
                    if (m_run[i] == D + 1) begin m_p[i] = 1'b0; r[i] = 1'b1; end
                end else if (m_run[i] == 1) begin
                    m_t[i] = 0;
                end else begin
                    m_t[i]++;
                    l[i] = (m_t[i] == H);
                    s[i] = (m_t[i] >= H) && ((m_t[i] - H) % R == 0);
                end
            end
            m_s2 = m_s1;
            m_s1 = key_n;
            for (int i = 0; i < N; i++) if (|(m_p & ~(N'(1) << i))) s[i] = 1'b0;
            if (|{c, l, s, r}) begin
                e.cyc = cyc;
                e.ev  = {c, l, s, r};
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        logic [4*N-1:0] got;
        rec_t e;
        got = {click, long, step, release_evt};
        ntests++;
        if (pressed !== m_p) begin
            nfail++;
            $display("FAIL pressed cyc=%0d got=%b exp=%b", cyc, pressed, m_p);
        end
        if (got != '0 || (q.size() > 0 && q[0].cyc <= cyc)) begin
            ntests++;
            if (q.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_event cyc=%0d got(c,l,s,r)=%b exp=none", cyc, got);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.ev !== got) begin
                    nfail++;
                    $display("FAIL events cyc=%0d got(c,l,s,r)=%b exp=%b at cyc=%0d", cyc, got, e.ev, e.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    initial begin
        #2 reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(3);
        // bounce, then hold into repeat
        repeat (3) begin key_n[0] = 1'b0; tick(2); key_n[0] = 1'b1; tick(2); end
        key_n[0] = 1'b0; tick(80);
        // release glitch while repeating
        key_n[0] = 1'b1; tick(3);
        key_n[0] = 1'b0; tick(40);
        // lockout: key1 pressed while key0 repeats
        key_n[1] = 1'b0; tick(35);
        key_n[1] = 1'b1; tick(25);
        key_n = '1; tick(20);
        // simultaneous press of key0 and key2
        key_n = 3'b010; tick(40);
        key_n = '1; tick(20);
        // reset mid-repeat with key still held
        key_n[0] = 1'b0; tick(40);
        reset_n = 1'b0;
        #1;
        ntests++;
        if ({pressed, click, long, step, release_evt} !== '0) begin
            nfail++;
            $display("FAIL reset_outputs got=%h exp=0", {pressed, click, long, step, release_evt});
        end
        tick(3);
        reset_n = 1'b1;
        tick(40);
        key_n = '1; tick(20);
        // random: alternating bouncy and calm stretches
        for (int it = 0; it < 400; it++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, (it % 50 < 8) ? 1 : 9) == 0) key_n[k] = ~key_n[k];
            tick($urandom_range(1, 6));
        end
        key_n = '1; tick(30);
        ntests++;
        if (q.size() != 0) begin
            nfail++;
            $display("FAIL leftover_events got=%0d exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/key_events.md
# key_events

Front-end key conditioner for the clock/edit design: it turns the raw, active-low, bouncing push-button pins into clean per-key events. Those events are debounced level, click, long-press, auto-repeat step and release. It sits between the board KEY pins and the time-keeping/edit-mode logic. The edit-mode logic consumes `long` to enter edit, `click` to advance fields, and `step` for plus/minus with hold-to-repeat.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: clock frequency. Must be a multiple of 1000. CPM = CLK_HZ/1000 cycles per ms.
- `N_KEYS`, 3: number of key channels.
- `DEBOUNCE_MS`, 10: stable time required on press and on release. D = DEBOUNCE_MS·CPM cycles.
- `HOLD_MS`, 1000: hold time before `long` and auto-repeat begin. H = HOLD_MS·CPM cycles.
- `REPEAT_MS`, 200: auto-repeat period. R = REPEAT_MS·CPM cycles.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `key_n` in N_KEYS: raw keys, active-low, asynchronous to `clk`.
- `pressed` out N_KEYS: debounced level, 1 = held.
- `click` out N_KEYS: 1-cycle pulse on debounced press.
- `long` out N_KEYS: 1-cycle pulse once H cycles after the press is accepted.
- `step` out N_KEYS: 1-cycle pulse on press, again at H, then every R cycles while held. Subject to lockout.
- `release` out N_KEYS: 1-cycle pulse on debounced release.

## Operation
- Per key, `key_n[i]` passes through a 2-flop synchronizer (flops reset to 1, i.e. released) into an independent FSM with a cycle counter `cnt`. Counter width is clog2(max(D,H,R)).
- **IDLE** (pressed=0): on sync=0 → DB_DN with cnt=0.
- **DB_DN**:
  - sync=1 → IDLE; bounce rejected, no pulses.
  - sync=0 and cnt=D-1 → HELD with cnt=0. Pulse `click` and `step`; set `pressed`=1.
- **HELD**:
  - sync=1 → DB_UP with cnt=0.
  - cnt=H-1 → REPEAT with cnt=0. Pulse `long` and `step`.
- **REPEAT**:
  - sync=1 → DB_UP with cnt=0.
  - cnt=R-1 → pulse `step`, cnt=0.
- **DB_UP** (pressed stays 1):
  - sync=0 → HELD with cnt=0. The hold timer restarts and no pulses are emitted.
  - sync=1 and cnt=D-1 → IDLE. Pulse `release`; set `pressed`=0.
- Lockout: `step[i]` is forced to 0 in any cycle where the registered `pressed[j]`=1 for any j≠i. `click`, `long`, `release` and `pressed` are never masked.
- Channels are fully independent otherwise. Simultaneous presses on different keys each produce their own events in the same cycle.

## Timing
- All outputs are registered. Every output resets to 0 asynchronously on `reset_n`=0.
- Reset puts all FSMs in IDLE, clears `cnt`, and sets the synchronizers to 1.
- Press latency: `pressed`/`click` rise exactly D+3 edges after the first edge that samples `key_n` low, provided the input stays low. This is 2 synchronizer edges, 1 edge to enter DB_DN, and D counting edges.
- Release latency: `pressed` falls and `release` pulses exactly D+3 edges after the first edge sampling `key_n` high.
- `long` and the second `step` occur H edges after `click`. Subsequent `step` pulses are spaced exactly R edges apart.
- Each pulse output is high for exactly 1 cycle. No two `step` pulses on one key are ever adjacent when R ≥ 2.
- Reset mid-operation: any in-flight state is discarded. If the key is still held when `reset_n` rises, the full press sequence repeats, including `click`.

## Structure
- Package `key_pkg`: state enum (IDLE, DB_DN, HELD, REPEAT, DB_UP), and a function `ms_to_cycles(ms, clk_hz)`.
- Sub-module `key_channel`: synchronizer, FSM, counter and pulse registers for one key, with parameters D/H/R.
- `key_events` instantiates N_KEYS channels via generate and applies the lockout mask to `step`.

## Test plan
Bench parameters: CLK_HZ=1000 (CPM=1), DEBOUNCE_MS=4, HOLD_MS=20, REPEAT_MS=5.
- **Bounce rejection**: `key_n[0]` low 2 cycles / high 2 cycles ×3, then low steady → exactly one `click` and `step`, 7 edges after the final fall. Nothing earlier.
- **Hold and repeat**: hold `key_n[0]` 60 cycles past `click` → `long` once at +20. `step` at +0, +20, +25, …, +55 (9 pulses). `pressed`=1 throughout.
- **Release glitch**: while in REPEAT, drive high 3 cycles then low → no `release`. The next `step` arrives 20 edges after returning to HELD. A stable high then gives `release` and `pressed`=0 7 edges after the edge.
- **Lockout**: key0 held in REPEAT, press key1 → key1 `click` fires, key1 `step` is suppressed, and key0 `step` pulses are masked while key1 `pressed`=1. key0 repeat resumes after key1 `release`.
- **Simultaneous press**: key0 and key2 fall on the same edge → both `click`s occur on the same cycle, and both `step`s are masked by mutual lockout.
- **Reset mid-REPEAT**: pull `reset_n` low → all outputs 0 immediately. Release reset with the key held → `click` again 7 edges later.
